// File: rtl/light_pkg.sv
// Shared types and lamp bit positions for the light mode controller.
// Used by light_mode_ctrl, which also honours the LIGHT_MODE_PEND_TIMEOUT_EN macro.
package light_pkg;

  typedef enum logic [1:0] {
    NORMAL      = 2'd0,
    PEND_FLASH  = 2'd1,
    FLASH       = 2'd2,
    PEND_NORMAL = 2'd3
  } mode_state_t;

  localparam int G_A = 0;
  localparam int Y_A = 1;
  localparam int R_A = 2;
  localparam int G_B = 3;
  localparam int Y_B = 4;
  localparam int R_B = 5;

  // Either direction showing yellow is a safe moment to hand over to flashing.
  function automatic logic any_yellow(input logic [5:0] lamps);
    return lamps[Y_A] | lamps[Y_B];
  endfunction

  function automatic logic is_flash_side(input mode_state_t s);
    return (s == FLASH) || (s == PEND_NORMAL);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on every accepted 0->1 transition.
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic          level;
  logic [CW-1:0] db_cnt;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; any agreeing sample restarts the stability window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      level  <= 1'b0;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      sync0 <= btn_raw;
      sync1 <= sync0;
      press <= 1'b0;
      if (sync1 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= sync1;
        db_cnt <= '0;
        press  <= sync1;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/light_mode_ctrl.sv
// Mode controller switching a traffic light between its normal sequence and flashing yellow.
// Define LIGHT_MODE_PEND_TIMEOUT_EN to force PEND_FLASH -> FLASH after PEND_MAX ticks.
module light_mode_ctrl
  import light_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000,
  parameter int PEND_MAX  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic [5:0] lamp_in,
  output logic       tick,
  output logic       flash_sel,
  output logic       ctrl_restart,
  output logic       mode_led
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;
  logic          press;
  logic          yellow;
  logic          restart_nxt;
  mode_state_t   state;
  mode_state_t   state_nxt;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_raw),
    .press  (press)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick   = (tick_cnt == TICK_LAST);
  assign yellow = any_yellow(lamp_in);

`ifdef LIGHT_MODE_PEND_TIMEOUT_EN
  localparam logic [7:0] PEND_LIM = 8'(PEND_MAX);

  logic [7:0] pend_cnt;
  logic [7:0] pend_nxt;
  logic [7:0] pend_inc;

  assign pend_inc = (pend_cnt >= PEND_LIM) ? PEND_LIM : pend_cnt + 8'd1;
`endif

  // A press always wins over a coincident tick, so the tick-driven arms
  // are only reached from the else branch of the press test.
  always_comb begin
    state_nxt   = state;
    restart_nxt = 1'b0;
`ifdef LIGHT_MODE_PEND_TIMEOUT_EN
    pend_nxt    = pend_cnt;
`endif
    case (state)
      NORMAL: begin
        if (press) begin
          state_nxt = PEND_FLASH;
`ifdef LIGHT_MODE_PEND_TIMEOUT_EN
          pend_nxt  = 8'd0;
`endif
        end
      end
      PEND_FLASH: begin
        if (press) begin
          state_nxt = NORMAL;
        end else if (tick) begin
          if (yellow) begin
            state_nxt = FLASH;
          end else begin
`ifdef LIGHT_MODE_PEND_TIMEOUT_EN
            pend_nxt = pend_inc;
            if (pend_inc == PEND_LIM) begin
              state_nxt = FLASH;
            end
`endif
          end
        end
      end
      FLASH: begin
        if (press) begin
          state_nxt = PEND_NORMAL;
`ifdef LIGHT_MODE_PEND_TIMEOUT_EN
          pend_nxt  = 8'd0;
`endif
        end
      end
      PEND_NORMAL: begin
        if (press) begin
          state_nxt = FLASH;
        end else if (tick) begin
          state_nxt   = NORMAL;
          restart_nxt = 1'b1;
        end
      end
      default: state_nxt = NORMAL;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= NORMAL;
      flash_sel    <= 1'b0;
      mode_led     <= 1'b0;
      ctrl_restart <= 1'b0;
    end else begin
      state        <= state_nxt;
      flash_sel    <= is_flash_side(state_nxt);
      mode_led     <= (state_nxt != NORMAL);
      ctrl_restart <= restart_nxt;
    end
  end

`ifdef LIGHT_MODE_PEND_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_cnt <= 8'd0;
    end else begin
      pend_cnt <= pend_nxt;
    end
  end
`endif

endmodule
